// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting controller: state encoding,
// field limits and the digit-blink masks driven in each edit state.
package time_set_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT_H = 2'd1,
      ST_EDIT_M = 2'd2,
      ST_EDIT_S = 2'd3
   } state_t;

   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;
   localparam int SEC_MAX  = 59;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   // bit5 = hours tens ... bit0 = seconds units
   localparam logic [5:0] FLICK_NONE = 6'b000000;
   localparam logic [5:0] FLICK_H    = 6'b110000;
   localparam logic [5:0] FLICK_M    = 6'b001100;
   localparam logic [5:0] FLICK_S    = 6'b000011;

   // Blink mask that goes with a given state
   function automatic logic [5:0] flick_of(state_t s);
      case (s)
         ST_EDIT_H: return FLICK_H;
         ST_EDIT_M: return FLICK_M;
         ST_EDIT_S: return FLICK_S;
         default:   return FLICK_NONE;
      endcase
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo (MAX+1) up/down counter holding one editable time field.
// Load has priority over increment, increment over decrement.
module wrap_counter #(
   parameter int MAX   = 59,
   parameter int WIDTH = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [WIDTH-1:0] o_val
);

   localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX);

   logic [WIDTH-1:0] r_val;

   // Field register: capture, or step with wrap at both ends
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_val <= '0;
      end else if (i_load) begin
         r_val <= i_load_val;
      end else if (i_inc) begin
         // >= so an out-of-range captured value still wraps cleanly to 0
         r_val <= (r_val >= LP_MAX) ? '0 : r_val + 1'b1;
      end else if (i_dec) begin
         r_val <= (r_val == '0) ? LP_MAX : r_val - 1'b1;
      end
   end

   assign o_val = r_val;

endmodule

// File: rtl/time_set_controller.sv
// Time-setting mode sequencer: captures the running time, lets the user edit
// H/M/S with button pulses, blinks the field under edit and commits with a
// one-cycle load strobe. Abandons the edit after TIMEOUT_S idle seconds.
// Optional feature macro HOLD_REPEAT_EN adds i_btn_up_held and auto-repeat
// increments while the up button is held.
module time_set_controller
   import time_set_pkg::*;
#(
   parameter int TIMEOUT_S     = 30,
   parameter int REPEAT_DELAY  = 1000000,
   parameter int REPEAT_PERIOD = 400000
) (
   input  logic              i_clk_2MHz,
   input  logic              i_reset,
   input  logic              i_tick_1hz,
   input  logic              i_btn_mode,
   input  logic              i_btn_sel,
   input  logic              i_btn_up,
   input  logic              i_btn_down,
`ifdef HOLD_REPEAT_EN
   input  logic              i_btn_up_held,
`endif
   input  logic [HOUR_W-1:0] i_cur_h,
   input  logic [MIN_W-1:0]  i_cur_m,
   input  logic [SEC_W-1:0]  i_cur_s,
   output logic [HOUR_W-1:0] o_edit_h,
   output logic [MIN_W-1:0]  o_edit_m,
   output logic [SEC_W-1:0]  o_edit_s,
   output logic [5:0]        o_flick,
   output logic              o_set_active,
   output logic              o_load
);

   localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_S - 1);

   state_t     r_state;
   logic [5:0] r_flick;
   logic       r_set_active;
   logic       r_load;
   logic [7:0] r_idle_cnt;

   logic w_in_edit;
   logic w_btn_any;
   logic w_rep_step;
   logic w_enter;
   logic w_cancel;
   logic w_adv;
   logic w_act_up;
   logic w_act_dn;
   logic w_timeout;
   logic w_state_chg;

   // Decode the single action taken this cycle: mode > sel > up > down > repeat
   assign w_in_edit   = (r_state != ST_IDLE);
   assign w_btn_any   = i_btn_mode | i_btn_sel | i_btn_up | i_btn_down;
   assign w_enter     = ~w_in_edit & i_btn_mode;
   assign w_cancel    = w_in_edit & i_btn_mode;
   assign w_adv       = w_in_edit & ~i_btn_mode & i_btn_sel;
   assign w_act_up    = w_in_edit & ~i_btn_mode & ~i_btn_sel &
                        (i_btn_up | (~i_btn_down & w_rep_step));
   assign w_act_dn    = w_in_edit & ~i_btn_mode & ~i_btn_sel & ~i_btn_up & i_btn_down;
   // A button or repeat step in the same cycle as the tick resets the timer instead
   assign w_timeout   = w_in_edit & ~w_btn_any & ~w_rep_step & i_tick_1hz &
                        (r_idle_cnt == LP_TO_LAST);
   assign w_state_chg = w_enter | w_cancel | w_adv | w_timeout;

   // Field registers; all three capture the running time on entry
   wrap_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hours (
      .i_clk      (i_clk_2MHz),
      .i_rst_n    (i_reset),
      .i_load     (w_enter),
      .i_load_val (i_cur_h),
      .i_inc      (w_act_up & (r_state == ST_EDIT_H)),
      .i_dec      (w_act_dn & (r_state == ST_EDIT_H)),
      .o_val      (o_edit_h)
   );

   wrap_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_minutes (
      .i_clk      (i_clk_2MHz),
      .i_rst_n    (i_reset),
      .i_load     (w_enter),
      .i_load_val (i_cur_m),
      .i_inc      (w_act_up & (r_state == ST_EDIT_M)),
      .i_dec      (w_act_dn & (r_state == ST_EDIT_M)),
      .o_val      (o_edit_m)
   );

   wrap_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_seconds (
      .i_clk      (i_clk_2MHz),
      .i_rst_n    (i_reset),
      .i_load     (w_enter),
      .i_load_val (i_cur_s),
      .i_inc      (w_act_up & (r_state == ST_EDIT_S)),
      .i_dec      (w_act_dn & (r_state == ST_EDIT_S)),
      .o_val      (o_edit_s)
   );

   // Mode FSM with registered blink mask, active flag and commit strobe
   always_ff @(posedge i_clk_2MHz or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= ST_IDLE;
         r_flick      <= FLICK_NONE;
         r_set_active <= 1'b0;
         r_load       <= 1'b0;
      end else begin
         r_load <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_enter) begin
                  r_state      <= ST_EDIT_H;
                  r_flick      <= flick_of(ST_EDIT_H);
                  r_set_active <= 1'b1;
               end
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
               if (w_cancel || w_timeout) begin
                  r_state      <= ST_IDLE;
                  r_flick      <= FLICK_NONE;
                  r_set_active <= 1'b0;
               end else if (w_adv) begin
                  if (r_state == ST_EDIT_S) begin
                     r_state      <= ST_IDLE;
                     r_flick      <= FLICK_NONE;
                     r_set_active <= 1'b0;
                     r_load       <= 1'b1;
                  end else if (r_state == ST_EDIT_H) begin
                     r_state <= ST_EDIT_M;
                     r_flick <= flick_of(ST_EDIT_M);
                  end else begin
                     r_state <= ST_EDIT_S;
                     r_flick <= flick_of(ST_EDIT_S);
                  end
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_flick      <= FLICK_NONE;
               r_set_active <= 1'b0;
            end
         endcase
      end
   end

   // Idle-seconds timer: any activity restarts it, ticks count only while editing
   always_ff @(posedge i_clk_2MHz or negedge i_reset) begin
      if (!i_reset) begin
         r_idle_cnt <= '0;
      end else if (w_btn_any || w_rep_step || w_state_chg) begin
         r_idle_cnt <= '0;
      end else if (w_in_edit && i_tick_1hz) begin
         r_idle_cnt <= r_idle_cnt + 8'd1;
      end
   end

`ifdef HOLD_REPEAT_EN
   localparam int LP_RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int LP_RCW  = $clog2(LP_RMAX + 1);
   localparam logic [LP_RCW-1:0] LP_RD_LAST = LP_RCW'(REPEAT_DELAY - 1);
   localparam logic [LP_RCW-1:0] LP_RP_LAST = LP_RCW'(REPEAT_PERIOD - 1);

   logic [LP_RCW-1:0] r_rep_cnt;
   logic              r_rep_on;

   // A step fires on the last cycle of each repeat period after the initial delay
   assign w_rep_step = w_in_edit & i_btn_up_held & r_rep_on & (r_rep_cnt == LP_RP_LAST);

   // Hold timer: delay phase, then free-running period phase until release
   always_ff @(posedge i_clk_2MHz or negedge i_reset) begin
      if (!i_reset) begin
         r_rep_cnt <= '0;
         r_rep_on  <= 1'b0;
      end else if (!i_btn_up_held || !w_in_edit || w_state_chg) begin
         r_rep_cnt <= '0;
         r_rep_on  <= 1'b0;
      end else if (!r_rep_on) begin
         if (r_rep_cnt == LP_RD_LAST) begin
            r_rep_cnt <= '0;
            r_rep_on  <= 1'b1;
         end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
         end
      end else if (r_rep_cnt == LP_RP_LAST) begin
         r_rep_cnt <= '0;
      end else begin
         r_rep_cnt <= r_rep_cnt + 1'b1;
      end
   end
`else
   assign w_rep_step = 1'b0;
`endif

   assign o_flick      = r_flick;
   assign o_set_active = r_set_active;
   assign o_load       = r_load;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: a behavioural model predicts the
// full output vector for every clock; predictions are queued as stimulus is
// driven and popped when the DUT outputs are sampled after the edge.
module tb_time_set_controller;

   localparam int TO = 3;
   localparam int RD = 10;
   localparam int RP = 4;

   localparam logic [4:0] B_MODE = 5'b10000;
   localparam logic [4:0] B_SEL  = 5'b01000;
   localparam logic [4:0] B_UP   = 5'b00100;
   localparam logic [4:0] B_DN   = 5'b00010;
   localparam logic [4:0] B_TK   = 5'b00001;
   localparam logic [4:0] B_NONE = 5'b00000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0, b_mode = 1'b0, b_sel = 1'b0, b_up = 1'b0, b_dn = 1'b0;
   logic       held = 1'b0;
   logic [4:0] cur_h = '0;
   logic [5:0] cur_m = '0, cur_s = '0;
   logic [4:0] o_edit_h;
   logic [5:0] o_edit_m, o_edit_s, o_flick;
   logic       o_set_active, o_load;
   logic [24:0] dut_vec;

   int n_tests = 0;
   int n_fail  = 0;
   logic [24:0] exp_q[$];

   int m_st, m_h, m_m, m_s, m_idle, m_hcnt;
   bit m_load;

   time_set_controller #(.TIMEOUT_S(TO), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
      .i_clk_2MHz   (clk),
      .i_reset      (rst_n),
      .i_tick_1hz   (tick),
      .i_btn_mode   (b_mode),
      .i_btn_sel    (b_sel),
      .i_btn_up     (b_up),
      .i_btn_down   (b_dn),
`ifdef HOLD_REPEAT_EN
      .i_btn_up_held(held),
`endif
      .i_cur_h      (cur_h),
      .i_cur_m      (cur_m),
      .i_cur_s      (cur_s),
      .o_edit_h     (o_edit_h),
      .o_edit_m     (o_edit_m),
      .o_edit_s     (o_edit_s),
      .o_flick      (o_flick),
      .o_set_active (o_set_active),
      .o_load       (o_load)
   );

   assign dut_vec = {o_edit_h, o_edit_m, o_edit_s, o_flick, o_set_active, o_load};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0; m_hcnt = 0; m_load = 0;
   endfunction

   function automatic void bump(input int d);
      case (m_st)
         1: m_h = (m_h + d + 24) % 24;
         2: m_m = (m_m + d + 60) % 60;
         3: m_s = (m_s + d + 60) % 60;
         default: ;
      endcase
   endfunction

   // One clock of the reference behaviour
   function automatic void model_clk(input bit mode, input bit sel, input bit up,
                                     input bit dn, input bit tk, input bit hd);
      int nst;
      bit edit;
      bit step;
      int n;
      nst  = m_st;
      edit = (m_st != 0);
      step = 0;
      n    = 0;
      m_load = 0;
      if (edit && hd) begin
         n    = m_hcnt + 1;
         step = (n > RD) && (((n - RD) % RP) == 0);
      end
      if (!edit) begin
         if (mode) begin
            nst = 1; m_h = int'(cur_h); m_m = int'(cur_m); m_s = int'(cur_s);
         end
      end else if (mode) nst = 0;
      else if (sel) begin
         if (m_st == 3) begin nst = 0; m_load = 1; end
         else nst = m_st + 1;
      end
      else if (up)   bump(1);
      else if (dn)   bump(-1);
      else if (step) bump(1);
      if (mode || sel || up || dn || step || (nst != m_st)) m_idle = 0;
      else if (edit && tk) begin
         m_idle++;
         if (m_idle >= TO) begin nst = 0; m_idle = 0; end
      end
      m_hcnt = (nst != m_st) ? 0 : n;
      m_st   = nst;
   endfunction

   function automatic logic [24:0] m_vec();
      logic [5:0] f;
      case (m_st)
         1: f = 6'b110000;
         2: f = 6'b001100;
         3: f = 6'b000011;
         default: f = 6'b000000;
      endcase
      return {5'(m_h), 6'(m_m), 6'(m_s), f, 1'(m_st != 0), m_load};
   endfunction

   // Called at a negedge: drive, predict, clock, compare, return at next negedge
   task automatic cyc(input string tag, input logic [4:0] b);
      {b_mode, b_sel, b_up, b_dn, tick} = b;
      model_clk(b[4], b[3], b[2], b[1], b[0], held);
      exp_q.push_back(m_vec());
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) chk({tag, "_qempty"}, 32'd1, 32'd0);
      else chk(tag, 32'(dut_vec), 32'(exp_q.pop_front()));
      @(negedge clk);
      {b_mode, b_sel, b_up, b_dn, tick} = B_NONE;
   endtask

   initial begin
      logic [4:0] rb;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_state", 32'(dut_vec), 32'd0);
      rst_n = 1'b1;
      cyc("idle0", B_NONE);
      cyc("idle_up_ignored", B_UP);

      // entry captures running time
      cur_h = 5'd12; cur_m = 6'd34; cur_s = 6'd56;
      cyc("t1_enter", B_MODE);
      chk("t1_flick", 32'(o_flick), 32'h30);
      chk("t1_time", {15'd0, o_edit_h, o_edit_m, o_edit_s}, {15'd0, 5'd12, 6'd34, 6'd56});
      cur_h = 5'd1; cur_m = 6'd2; cur_s = 6'd3;
      cyc("t1_cur_ignored", B_NONE);

      // wrap boundaries
      cyc("t2_cancel", B_MODE);
      cur_h = 5'd23; cur_m = 6'd0; cur_s = 6'd9;
      cyc("t2_enter", B_MODE);
      cyc("t2_h_up_wrap", B_UP);
      chk("t2_h_is0", 32'(o_edit_h), 32'd0);
      cyc("t2_h_dn_wrap", B_DN);
      chk("t2_h_is23", 32'(o_edit_h), 32'd23);
      cyc("t2_sel_m", B_SEL);
      cyc("t2_m_dn_wrap", B_DN);
      chk("t2_m_is59", 32'(o_edit_m), 32'd59);
      cyc("t2_m_up_wrap", B_UP);
      cyc("t2_up_dn_prio", B_UP | B_DN);

      // commit
      cyc("t3_cancel", B_MODE);
      cur_h = 5'd5; cur_m = 6'd7; cur_s = 6'd9;
      cyc("t3_enter", B_MODE);
      cyc("t3_sel1", B_SEL);
      cyc("t3_sel2", B_SEL);
      cyc("t3_commit", B_SEL | B_UP);
      chk("t3_load", {7'd0, o_load, o_edit_h, o_edit_m, o_edit_s, o_flick},
          {7'd0, 1'b1, 5'd5, 6'd7, 6'd9, 6'd0});
      cyc("t3_load_drop", B_NONE);
      chk("t3_load_1cyc", 32'(o_load), 32'd0);

      // cancel and timeout
      cyc("t4_enter", B_MODE);
      cyc("t4_sel", B_SEL);
      cyc("t4_cancel_m", B_MODE | B_SEL);
      chk("t4_no_load", 32'({o_load, o_set_active}), 32'd0);
      cyc("t4_enter2", B_MODE);
      cyc("t4_sel_m", B_SEL);
      cyc("t4_sel_s", B_SEL);
      cyc("t4_tk1", B_TK);
      cyc("t4_gap", B_NONE);
      cyc("t4_tk2", B_TK);
      cyc("t4_tk_btn", B_TK | B_UP);
      cyc("t4_tk3", B_TK);
      cyc("t4_tk4", B_TK);
      chk("t4_still_edit", 32'(o_set_active), 32'd1);
      cyc("t4_timeout", B_TK);
      chk("t4_timed_out", 32'({o_set_active, o_load}), 32'd0);

      // simultaneous sel+up, then hold-repeat, then async reset mid-edit
      cur_h = 5'd10; cur_m = 6'd20; cur_s = 6'd57;
      cyc("t5_enter", B_MODE);
      cyc("t5_sel_up", B_SEL | B_UP);
      chk("t5_h_kept", {26'd0, o_flick}, {26'd0, 6'b001100});
      chk("t5_h_val", 32'(o_edit_h), 32'd10);
      cyc("t5_sel_s", B_SEL);
`ifdef HOLD_REPEAT_EN
      cyc("t6_tk1", B_TK);
      cyc("t6_tk2", B_TK);
      held = 1'b1;
      for (int i = 0; i < 30; i++) cyc("t6_hold", B_NONE);
      held = 1'b0;
      chk("t6_s_plus5", 32'(o_edit_s), 32'd2);
      cyc("t6_tk3", B_TK);
      cyc("t6_tk4", B_TK);
      chk("t6_idle_cleared", 32'(o_set_active), 32'd1);
`endif
      #2 rst_n = 1'b0;
      #1 chk("t5_async_rst", 32'(dut_vec), 32'd0);
      model_reset();
      @(negedge clk);
      chk("t5_rst_hold", 32'(dut_vec), 32'd0);
      rst_n = 1'b1;
      cyc("t5_after_rst", B_NONE);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         rb = B_NONE;
         if ($urandom_range(0, 15) == 0) rb |= B_MODE;
         if ($urandom_range(0, 7)  == 0) rb |= B_SEL;
         if ($urandom_range(0, 3)  == 0) rb |= B_UP;
         if ($urandom_range(0, 3)  == 0) rb |= B_DN;
         if ($urandom_range(0, 2)  == 0) rb |= B_TK;
         cur_h = 5'($urandom_range(0, 23));
         cur_m = 6'($urandom_range(0, 59));
         cur_s = 6'($urandom_range(0, 59));
`ifdef HOLD_REPEAT_EN
         if ($urandom_range(0, 19) == 0) held = ~held;
         if (held) rb = rb & ~($urandom_range(0, 1) == 0 ? (B_UP | B_DN) : B_NONE);
`endif
         cyc("rand", rb);
      end
      held = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
